// File: rtl/fifo_drain_tx.sv
// Pulls bytes from a registered-read synchronous FIFO and sends each one as a
// start bit, DATA_W data bits (LSB first) and a stop bit on a single wire.
module fifo_drain_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        o_dbg_state
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic              ONE_CLK   = (CLKS_PER_BIT == 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t             r_state;
    logic [BAUD_W-1:0]  r_baud;
    logic [BIT_W-1:0]   r_bit;
    logic [DATA_W-1:0]  r_shift;
    logic               r_tx;
    logic               r_rd_en;
    logic               r_busy;
    logic               r_done;
    logic               w_baud_end;

    assign w_baud_end = (r_baud == BAUD_LAST);

    // FIFO handshake: fifo_rd_en is a one-cycle strobe issued only while the
    // FIFO reports non-empty; fifo_dout is valid one cycle later and is
    // captured in LOAD. Every other cycle fifo_dout is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        r_state <= S_READ;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift <= fifo_dout;
                    r_tx    <= 1'b0;
                    r_baud  <= '0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                            // With one clock per bit the stop bit is also its own last cycle
                            r_done  <= ONE_CLK;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        if (r_baud == BAUD_PRE) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en  = r_rd_en;
    assign tx          = r_tx;
    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Bench for fifo_drain_tx: behavioural FIFO, a bit-slot serial decoder and a
// byte scoreboard; each scenario task checks its own results inline.
module tb_fifo_drain_tx;

    localparam int DW     = 8;
    localparam int CPB    = 4;
    localparam int BUSY_T = 2 + (DW + 2) * CPB;
    localparam int PERIOD = BUSY_T + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          frame_done;
    logic [2:0]    dbg_state;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fifo_drain_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .tx(tx), .busy(busy),
        .frame_done(frame_done), .o_dbg_state(dbg_state)
    );

    // Behavioural FIFO: registered read data and registered empty flag
    logic [DW-1:0] mem_q[$];
    int underflow = 0;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (mem_q.size() > 0) fifo_dout <= mem_q.pop_front();
            else underflow++;
        end
        fifo_empty <= (mem_q.size() == 0);
    end

    // Monitor and serial decoder sampled on the falling edge
    int cyc = 0;
    int rd_cyc_q[$];
    int done_cyc_q[$];
    int busy_len_q[$];
    int busy_run = 0;
    logic tx_hist[int];
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] exp_q[$];
    int rx_glitch = 0;
    bit rx_active = 0;
    int rx_cnt = 0;
    int slot = 0;
    logic rx_cur = 1'b1;
    logic [DW-1:0] rx_byte = '0;

    always @(negedge clk) begin
        cyc++;
        tx_hist[cyc] = tx;
        if (fifo_rd_en) rd_cyc_q.push_back(cyc);
        if (frame_done) done_cyc_q.push_back(cyc);
        if (busy) busy_run++;
        else if (busy_run > 0) begin
            busy_len_q.push_back(busy_run);
            busy_run = 0;
        end
        if (reset) begin
            rx_active = 0;
            busy_run = 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1;
                rx_cnt = 1;
                rx_cur = 1'b0;
            end
        end else begin
            if (rx_cnt % CPB == 0) begin
                rx_cur = tx;
                slot = rx_cnt / CPB;
                if (slot >= 1 && slot <= DW) rx_byte[slot-1] = tx;
                if (slot == DW + 1 && tx !== 1'b1) rx_glitch++;
            end else if (tx !== rx_cur) begin
                rx_glitch++;
            end
            if (rx_cnt == (DW + 2) * CPB - 1) begin
                rx_q.push_back(rx_byte);
                rx_active = 0;
            end
            rx_cnt++;
        end
    end

    // Expected line level k cycles after the read strobe: LOAD idle-high,
    // start slot, DATA_W data slots LSB first, then the stop slot.
    function automatic logic exp_tx(input logic [DW-1:0] b, input int k);
        int s;
        if (k == 1) return 1'b1;
        s = (k - 2) / CPB;
        if (s == 0) return 1'b0;
        if (s <= DW) return b[s-1];
        return 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rd_cyc_q.delete();
        done_cyc_q.delete();
        busy_len_q.delete();
        rx_q.delete();
        exp_q.delete();
        tx_hist.delete();
        rx_glitch = 0;
        underflow = 0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (rx_q.size() >= n) begin
                ok = 1;
                break;
            end
        end
        tick(3);
    endtask

    task automatic test_reset();
        logic [DW-1:0] b;
        bit ok;
        b = DW'($urandom_range(0, 255));
        enable = 1'b1;
        mem_q.push_back(b);
        exp_q.push_back(b);
        for (int i = 0; i < 2; i++) begin
            tick(1);
            checks++;
            if ({tx, fifo_rd_en, busy, frame_done} !== 4'b1000) $display("FAIL reset_outputs cycle %0d: got %b want 1000", i, {tx, fifo_rd_en, busy, frame_done});
            else passed++;
        end
        reset = 1'b0;
        tick(1);
        checks++;
        if (fifo_rd_en !== 1'b1) $display("FAIL first_read: rd_en %b want 1", fifo_rd_en);
        else passed++;
        wait_rx(1, 200, ok);
        checks++;
        if (!ok || rx_q[0] !== exp_q[0]) $display("FAIL reset_first_byte: got %h want %h (ok=%0d)", ok ? rx_q[0] : 'x, exp_q[0], ok);
        else passed++;
    endtask

    task automatic test_single_frame();
        bit ok;
        int r, bad;
        logic [DW-1:0] b;
        clear_mon();
        b = 8'hA1;
        mem_q.push_back(b);
        exp_q.push_back(b);
        enable = 1'b1;
        wait_rx(1, 200, ok);
        checks++;
        if (rd_cyc_q.size() !== 1) $display("FAIL single_rd_count: got %0d want 1", rd_cyc_q.size());
        else passed++;
        r = (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1000;
        bad = 0;
        for (int k = 1; k <= BUSY_T - 1; k++) begin
            if (!tx_hist.exists(r + k) || tx_hist[r + k] !== exp_tx(b, k)) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL single_tx_wave: %0d bad cycles want 0", bad);
        else passed++;
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] - r != BUSY_T - 1) $display("FAIL single_done_latency: count %0d latency %0d want 1/%0d", done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] - r : -1, BUSY_T - 1);
        else passed++;
        checks++;
        if (busy_len_q.size() != 1 || busy_len_q[0] != BUSY_T) $display("FAIL single_busy_len: got %0d want %0d", (busy_len_q.size() > 0) ? busy_len_q[0] : -1, BUSY_T);
        else passed++;
        checks++;
        if (!ok || rx_q[0] !== exp_q[0]) $display("FAIL single_byte: got %h want %h", ok ? rx_q[0] : 'x, exp_q[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [DW-1:0] bytes[3];
        clear_mon();
        bytes[0] = 8'h9A;
        bytes[1] = 8'hBC;
        bytes[2] = 8'hDE;
        for (int i = 0; i < 3; i++) begin
            mem_q.push_back(bytes[i]);
            exp_q.push_back(bytes[i]);
        end
        enable = 1'b1;
        wait_rx(3, 3 * PERIOD + 100, ok);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 'x, exp_q[i]);
            else passed++;
        end
        checks++;
        if (rd_cyc_q.size() != 3 || rd_cyc_q[1] - rd_cyc_q[0] != PERIOD || rd_cyc_q[2] - rd_cyc_q[1] != PERIOD)
            $display("FAIL b2b_rd_spacing: count %0d gaps %0d/%0d want 3 %0d/%0d", rd_cyc_q.size(),
                     (rd_cyc_q.size() >= 2) ? rd_cyc_q[1] - rd_cyc_q[0] : -1, (rd_cyc_q.size() >= 3) ? rd_cyc_q[2] - rd_cyc_q[1] : -1, PERIOD, PERIOD);
        else passed++;
        checks++;
        if (done_cyc_q.size() != 3 || done_cyc_q[1] - done_cyc_q[0] != PERIOD || done_cyc_q[2] - done_cyc_q[1] != PERIOD)
            $display("FAIL b2b_done_spacing: count %0d want 3 with gaps %0d", done_cyc_q.size(), PERIOD);
        else passed++;
        tick(20);
        checks++;
        if ({tx, busy, rd_cyc_q.size() == 3, rx_glitch == 0, underflow == 0} !== 5'b10111)
            $display("FAIL b2b_final_idle: tx %b busy %b rd %0d glitch %0d underflow %0d want 1 0 3 0 0", tx, busy, rd_cyc_q.size(), rx_glitch, underflow);
        else passed++;
    endtask

    task automatic test_empty_idle();
        int rd_seen, busy_seen, tx_low;
        clear_mon();
        enable = 1'b1;
        rd_seen = 0;
        busy_seen = 0;
        tx_low = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (fifo_rd_en !== 1'b0) rd_seen++;
            if (busy !== 1'b0) busy_seen++;
            if (tx !== 1'b1) tx_low++;
        end
        checks++;
        if (rd_seen != 0) $display("FAIL empty_rd_en: %0d strobes want 0", rd_seen);
        else passed++;
        checks++;
        if (busy_seen != 0 || tx_low != 0) $display("FAIL empty_idle_line: busy %0d tx_low %0d want 0 0", busy_seen, tx_low);
        else passed++;
    endtask

    task automatic test_enable_drop();
        bit ok;
        logic [DW-1:0] b0, b1;
        clear_mon();
        b0 = DW'($urandom_range(0, 255));
        b1 = DW'($urandom_range(0, 255));
        mem_q.push_back(b0);
        mem_q.push_back(b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        enable = 1'b1;
        for (int i = 0; i < 20 && rd_cyc_q.size() == 0; i++) tick(1);
        tick(14);
        checks++;
        if (busy !== 1'b1 || rd_cyc_q.size() != 1) $display("FAIL drop_mid_frame: busy %b rd %0d want 1 1", busy, rd_cyc_q.size());
        else passed++;
        enable = 1'b0;
        tick(150);
        checks++;
        if (rd_cyc_q.size() != 1 || mem_q.size() != 1) $display("FAIL drop_no_fetch: rd %0d fifo_left %0d want 1 1", rd_cyc_q.size(), mem_q.size());
        else passed++;
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== exp_q[0] || rx_glitch != 0) $display("FAIL drop_frame1: count %0d byte %h glitch %0d want 1 %h 0", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 'x, rx_glitch, exp_q[0]);
        else passed++;
        enable = 1'b1;
        wait_rx(2, 200, ok);
        checks++;
        if (!ok || rx_q[1] !== exp_q[1] || rd_cyc_q.size() != 2) $display("FAIL drop_resume: byte %h rd %0d want %h 2", ok ? rx_q[1] : 'x, rd_cyc_q.size(), exp_q[1]);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [DW-1:0] c1;
        int r;
        clear_mon();
        c1 = 8'hC1;
        mem_q.push_back(c1);
        enable = 1'b1;
        for (int i = 0; i < 20 && rd_cyc_q.size() == 0; i++) tick(1);
        tick(19);
        checks++;
        if (tx !== c1[3] || busy !== 1'b1) $display("FAIL rst_pre_bit3: tx %b busy %b want %b 1", tx, busy, c1[3]);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) $display("FAIL rst_async: tx %b busy %b done %b want 1 0 0", tx, busy, frame_done);
        else passed++;
        clear_mon();
        mem_q.push_back(8'hD1);
        exp_q.push_back(8'hD1);
        tick(2);
        reset = 1'b0;
        wait_rx(1, 200, ok);
        r = (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1000;
        checks++;
        if (!ok || rx_q.size() != 1 || rx_q[0] !== exp_q[0] || rx_glitch != 0) $display("FAIL rst_next_frame: count %0d byte %h glitch %0d want 1 %h 0", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 'x, rx_glitch, exp_q[0]);
        else passed++;
        checks++;
        if (rd_cyc_q.size() != 1 || done_cyc_q.size() != 1 || done_cyc_q[0] - r != BUSY_T - 1 || underflow != 0)
            $display("FAIL rst_fresh_read: rd %0d done %0d latency %0d underflow %0d want 1 1 %0d 0", rd_cyc_q.size(), done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] - r : -1, underflow, BUSY_T - 1);
        else passed++;
    endtask

    task automatic test_random_stream();
        bit ok;
        int bad_len, min_gap;
        logic [DW-1:0] b;
        clear_mon();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = DW'($urandom_range(0, 255));
            mem_q.push_back(b);
            exp_q.push_back(b);
            tick($urandom_range(0, 60));
        end
        wait_rx(6, 6 * PERIOD + 100, ok);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 'x, exp_q[i]);
            else passed++;
        end
        bad_len = 0;
        foreach (busy_len_q[i]) if (busy_len_q[i] != BUSY_T) bad_len++;
        min_gap = PERIOD;
        for (int i = 1; i < rd_cyc_q.size(); i++) if (rd_cyc_q[i] - rd_cyc_q[i-1] < min_gap) min_gap = rd_cyc_q[i] - rd_cyc_q[i-1];
        checks++;
        if (bad_len != 0 || busy_len_q.size() != 6 || min_gap < PERIOD || rx_glitch != 0 || underflow != 0)
            $display("FAIL rand_timing: bad_len %0d frames %0d min_gap %0d glitch %0d underflow %0d want 0 6 >=%0d 0 0", bad_len, busy_len_q.size(), min_gap, rx_glitch, underflow, PERIOD);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_empty_idle();
        test_enable_drop();
        test_reset_mid_frame();
        test_random_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_drain_tx.md
Name: fifo_drain_tx

Overview:
Read-side consumer for the team's 8-deep synchronous FIFO. It pulls one byte at a time through the FIFO's read_enable/empty/dout port, honouring the FIFO's one-cycle registered read latency. Each byte is serialized onto a single-wire, UART-style frame: one start bit (0), DATA_W data bits LSB first, and one stop bit (1). It sits between the FIFO output and an off-block serial line.

Parameters:
DATA_W, 8, data width in bits; must match the FIFO word width.
CLKS_PER_BIT, 4, clock cycles per serial bit; must be >= 1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  permits new fetches from the FIFO; sampled only in IDLE.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  read strobe to the FIFO; registered, one-cycle pulse.
fifo_dout  input  DATA_W  FIFO registered read data; valid the cycle after the rd_en edge.
tx  output  1  serial line; idles high.
busy  output  1  high whenever state != IDLE.
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, tx = 1, fifo_rd_en = 0, busy = 0, frame_done = 0.
  - Baud counter, bit counter and shift register cleared.
- States: IDLE, READ, LOAD, START, DATA, STOP.
- IDLE:
  - tx = 1.
  - If enable && !fifo_empty, go to READ.
  - Otherwise stay in IDLE; fifo_rd_en is never asserted.
- READ (1 cycle):
  - fifo_rd_en = 1 in this cycle only. The FIFO samples it at the closing edge and updates fifo_dout.
  - Go to LOAD.
- LOAD (1 cycle):
  - fifo_rd_en = 0; tx = 1.
  - shift_reg <= fifo_dout at the closing edge.
  - Go to START.
- START:
  - tx = 0 for exactly CLKS_PER_BIT cycles.
  - Go to DATA with bit index 0.
- DATA:
  - tx = shift_reg[bit index], each bit held CLKS_PER_BIT cycles, LSB first.
  - After bit DATA_W-1, go to STOP.
- STOP:
  - tx = 1 for CLKS_PER_BIT cycles.
  - frame_done = 1 on the final STOP cycle.
  - Go to IDLE. There is always at least one IDLE cycle between frames.
- Timing:
  - Busy time per frame is 2 + (DATA_W+2)*CLKS_PER_BIT cycles; 42 cycles at the defaults.
  - Back-to-back frame period is 43 cycles at the defaults.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT), minimum 1 bit. It counts 0..CLKS_PER_BIT-1 and reloads to 0 on each bit boundary.
  - Bit counter width is clog2(DATA_W). No wrap is permitted beyond DATA_W-1.
- Boundary conditions:
  - fifo_empty rising during READ/LOAD: ignored, because the read was already committed while the FIFO was non-empty.
  - fifo_empty while in IDLE: no strobe issued, ever.
  - enable deasserted mid-frame: the current frame completes unchanged; no further fetch.
  - enable and fifo_empty are not sampled outside IDLE.
  - fifo_dout changes outside LOAD: ignored.
  - Reset mid-frame:
    - tx returns to 1 and busy to 0 immediately.
    - The partially sent byte is lost; no re-read.
    - After release, the next frame begins with a fresh READ.
- Outputs tx, fifo_rd_en, busy and frame_done have no combinational path from any input.

Test Plan:
1. Assert reset for 2 cycles with enable=1 and fifo_empty=0 -> tx=1, fifo_rd_en=0, busy=0, frame_done=0 throughout; first READ occurs 1 cycle after release.
2. FIFO holds 8'hA1, enable=1, CLKS_PER_BIT=4 -> exactly one fifo_rd_en pulse. tx sequence: 1 (LOAD), 0 x4, then bits 1,0,0,0,0,1,0,1 each x4, then 1 x4. frame_done pulses once, 41 cycles after the rd_en cycle. busy high for 42 cycles.
3. FIFO preloaded with 8'h9A, 8'hBC, 8'hDE, enable held -> three frames in order carrying those bytes, three rd_en pulses 43 cycles apart, frame_done spacing 43 cycles; then IDLE with tx=1 once the FIFO is empty.
4. fifo_empty=1, enable=1 for 100 cycles -> fifo_rd_en never asserted, tx=1, busy=0.
5. Two bytes queued; drop enable during DATA of frame 1 -> frame 1 completes intact, no second rd_en, second byte remains in the FIFO; re-raising enable sends it.
6. Reset asserted during DATA bit 3 of 8'hC1 -> tx=1 and busy=0 in the same cycle; after release with the FIFO holding 8'hD1, the next frame carries 8'hD1 with a full start bit.
